cpu_mem_arbiter: RTL and testbench
==================================

Name: cpu_mem_arbiter

Overview:
- Shares one single-port synchronous memory between the fetch stage (instruction reads) and the execute stage (loads and stores) of the pipelined CPU.
- Grants at most one memory command per cycle. Data accesses have priority over fetch.
- Returns read data or store completion with a valid pulse. Drives per-requester stall signals consumed by the pipeline control blocks.
- Exports a saturating fetch-stall counter for performance measurement.

Parameters:
- AW, 16, memory address width.
- DW, 16, data width.
- RD_LAT, 1, memory read latency in cycles. Legal range 1..7.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_if_req  in  1  fetch read request; held with i_if_addr until o_if_valid
- i_if_addr  in  AW  fetch address
- o_if_valid  out  1  fetch data valid pulse
- o_if_rdata  out  DW  fetch data; equals i_mem_rdata, meaningful only while o_if_valid
- o_if_stall  out  1  i_if_req & ~o_if_valid
- i_ld_req  in  1  load request; held until o_d_valid
- i_st_req  in  1  store request; held until o_d_valid
- i_d_addr  in  AW  load/store address
- i_d_wdata  in  DW  store data
- o_d_valid  out  1  load data valid / store done pulse
- o_d_rdata  out  DW  load data; equals i_mem_rdata, meaningful only while o_d_valid
- o_d_stall  out  1  (i_ld_req|i_st_req) & ~o_d_valid
- o_mem_addr  out  AW  memory address; muxed from the granted requester
- o_mem_rd  out  1  memory read strobe
- o_mem_wr  out  1  memory write strobe
- o_mem_wdata  out  DW  memory write data
- i_mem_rdata  in  DW  memory read data; valid RD_LAT cycles after o_mem_rd
- o_busy  out  1  a transaction is outstanding (state WAIT)
- o_if_stall_cnt  out  16  count of cycles with o_if_stall=1, saturating at 0xFFFF

Behaviour:
- State registers:
  - state: IDLE or WAIT.
  - owner: IF or D.
  - op: RD or WR.
  - cnt: 3 bits.
- Port free: state==IDLE, or state==WAIT with cnt==0. In a free WAIT cycle the outstanding transaction completes.
- Eligibility:
  - A requester is eligible when its request is high, the port is free, and it is not the owner completing in the current cycle.
  - The completing owner's held request belongs to the finished transaction and is never re-granted in its own valid cycle.
- Grant, combinational, when the port is free:
  - D eligible: grant D. Otherwise IF eligible: grant IF. Otherwise no grant.
  - Granted read: o_mem_rd=1 and o_mem_addr from the granted requester.
  - Granted store: o_mem_wr=1, o_mem_addr=i_d_addr, o_mem_wdata=i_d_wdata. Memory is written at the edge ending the grant cycle.
  - i_ld_req and i_st_req both high is treated as a store.
  - o_mem_rd and o_mem_wr are never high in the same cycle. Each is high for exactly one cycle per grant.
- State update at the grant edge: state<=WAIT, owner/op latched, cnt<=RD_LAT-1 for reads, cnt<=0 for stores.
- In WAIT with cnt!=0: cnt decrements and no grant is made.
- In WAIT with cnt==0:
  - Pulse o_if_valid or o_d_valid according to owner.
  - If a new grant is made in the same cycle, reload state/owner/op/cnt. Otherwise state<=IDLE.
- Latency:
  - Read granted in cycle t: valid in cycle t+RD_LAT.
  - Store granted in cycle t: o_d_valid in cycle t+1.
  - With RD_LAT=1, alternating requesters sustain one command per cycle. A single requester achieves one access per 2 cycles.
- Stall counter: increments on every cycle with o_if_stall=1 and holds at 0xFFFF.
- Reset:
  - While i_reset is high, o_mem_rd/o_mem_wr/o_if_valid/o_d_valid are forced to 0.
  - Reset values: state=IDLE, cnt=0, owner=IF, op=RD, o_busy=0, o_if_stall_cnt=0.
  - Reset mid-transaction discards it. No valid pulse is produced for it after release.
- Address and data inputs are sampled only in the grant cycle. Requesters keep them stable until valid.

Test Plan:
- RD_LAT=1, fetch only, i_if_addr=0x0010, memory returns 0xABCD → o_mem_rd=1 with o_mem_addr=0x0010 at t; o_if_valid=1 with o_if_rdata=0xABCD at t+1; o_if_stall high only at t.
- RD_LAT=1, fetch 0x0020 and load 0x0100 raised together at t → load granted at t, o_d_valid at t+1; fetch granted at t+1, o_if_valid at t+2; o_if_stall_cnt increments by 2.
- Store to 0x0200 with 0x1234 plus fetch at t → o_mem_wr=1, o_mem_addr=0x0200, o_mem_wdata=0x1234 at t; o_d_valid at t+1; fetch o_mem_rd at t+1; no cycle has both strobes high.
- RD_LAT=3, load 0x0040 at t, fetch raised at t+1 → o_d_valid at t+3; fetch granted at t+3, o_if_valid at t+6; o_busy high t+1..t+6.
- RD_LAT=3, load at t, i_reset pulsed at t+1 → no o_d_valid ever; strobes 0 during reset; o_if_stall_cnt=0. After release, a fetch completes with normal latency.
- i_ld_req and i_st_req both high → a single write is issued (o_mem_wr=1, o_mem_rd=0) and one o_d_valid pulse follows.

Source files
------------

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares one single-port synchronous memory between fetch and load/store,
// with data accesses taking priority and a saturating fetch-stall counter.
module cpu_mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int RD_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_valid,
  output logic [DW-1:0] o_if_rdata,
  output logic          o_if_stall,
  input  logic          i_ld_req,
  input  logic          i_st_req,
  input  logic [AW-1:0] i_d_addr,
  input  logic [DW-1:0] i_d_wdata,
  output logic          o_d_valid,
  output logic [DW-1:0] o_d_rdata,
  output logic          o_d_stall,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_rd,
  output logic          o_mem_wr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_busy,
  output logic [15:0]   o_if_stall_cnt
);
  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;
  typedef enum logic {OP_RD, OP_WR} op_t;
  localparam logic [2:0] RD_CNT = 3'(RD_LAT - 1);
  state_t     state;
  owner_t     owner;
  op_t        op;
  logic [2:0] cnt;
  logic       done, free, d_req, d_elig, if_elig, gnt_d, gnt_if, gnt_wr;
  assign done = (state == WAIT) && (cnt == 3'd0);
  assign free = (state == IDLE) || done;
  assign d_req = i_ld_req | i_st_req;
  // the completing owner's still-held request belongs to the finished access
  assign d_elig = d_req && free && !(done && owner == OWN_D);
  assign if_elig = i_if_req && free && !(done && owner == OWN_IF);
  assign gnt_d = d_elig;
  assign gnt_if = if_elig && !d_elig;
  assign gnt_wr = gnt_d && i_st_req;
  assign o_mem_rd = !i_reset && (gnt_if || (gnt_d && !i_st_req));
  assign o_mem_wr = !i_reset && gnt_wr;
  assign o_mem_addr = gnt_d ? i_d_addr : i_if_addr;
  assign o_mem_wdata = i_d_wdata;
  assign o_if_valid = !i_reset && done && owner == OWN_IF;
  assign o_d_valid = !i_reset && done && owner == OWN_D;
  assign o_if_rdata = i_mem_rdata;
  assign o_d_rdata = i_mem_rdata;
  assign o_if_stall = i_if_req && !o_if_valid;
  assign o_d_stall = d_req && !o_d_valid;
  assign o_busy = state == WAIT;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
      owner <= OWN_IF;
      op <= OP_RD;
      cnt <= 3'd0;
      o_if_stall_cnt <= 16'd0;
    end else begin
      if (gnt_d || gnt_if) begin
        state <= WAIT;
        owner <= gnt_d ? OWN_D : OWN_IF;
        op <= gnt_wr ? OP_WR : OP_RD;
        cnt <= gnt_wr ? 3'd0 : RD_CNT;
      end else if (state == WAIT && op == OP_RD && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end else if (done) begin
        state <= IDLE;
      end
      if (o_if_stall && o_if_stall_cnt != 16'hFFFF)
        o_if_stall_cnt <= o_if_stall_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: directed checks of two arbiter instances (RD_LAT=1 and RD_LAT=3)
// with a scoreboard matching returned read data against a behavioural memory.
module tb_cpu_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic lat3;
  logic if_req, ld_req, st_req;
  logic [15:0] if_addr, d_addr, d_wdata;
  logic if_valid1, if_stall1, d_valid1, d_stall1, mem_rd1, mem_wr1, busy1;
  logic [15:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1, stall_cnt1;
  logic if_valid3, if_stall3, d_valid3, d_stall3, mem_rd3, mem_wr3, busy3;
  logic [15:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3, stall_cnt3;
  logic if_valid, if_stall, d_valid, d_stall, mem_rd, mem_wr, busy;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, stall_cnt;
  logic [15:0] m1 [0:1023];
  logic [15:0] m3 [0:1023];
  logic [15:0] rd1;
  logic [15:0] p3 [0:2];
  logic [15:0] if_q [$];
  logic [16:0] d_q [$];
  logic [16:0] exp_d;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpu_mem_arbiter #(.AW(16), .DW(16), .RD_LAT(1)) u1 (
    .i_clk(clk), .i_reset(rst), .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_valid(if_valid1), .o_if_rdata(if_rdata1), .o_if_stall(if_stall1),
    .i_ld_req(ld_req), .i_st_req(st_req), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_valid(d_valid1), .o_d_rdata(d_rdata1), .o_d_stall(d_stall1),
    .o_mem_addr(mem_addr1), .o_mem_rd(mem_rd1), .o_mem_wr(mem_wr1),
    .o_mem_wdata(mem_wdata1), .i_mem_rdata(mem_rdata1), .o_busy(busy1),
    .o_if_stall_cnt(stall_cnt1));

  cpu_mem_arbiter #(.AW(16), .DW(16), .RD_LAT(3)) u3 (
    .i_clk(clk), .i_reset(rst), .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_valid(if_valid3), .o_if_rdata(if_rdata3), .o_if_stall(if_stall3),
    .i_ld_req(ld_req), .i_st_req(st_req), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_valid(d_valid3), .o_d_rdata(d_rdata3), .o_d_stall(d_stall3),
    .o_mem_addr(mem_addr3), .o_mem_rd(mem_rd3), .o_mem_wr(mem_wr3),
    .o_mem_wdata(mem_wdata3), .i_mem_rdata(mem_rdata3), .o_busy(busy3),
    .o_if_stall_cnt(stall_cnt3));

  assign if_valid = lat3 ? if_valid3 : if_valid1;
  assign if_stall = lat3 ? if_stall3 : if_stall1;
  assign d_valid = lat3 ? d_valid3 : d_valid1;
  assign d_stall = lat3 ? d_stall3 : d_stall1;
  assign mem_rd = lat3 ? mem_rd3 : mem_rd1;
  assign mem_wr = lat3 ? mem_wr3 : mem_wr1;
  assign busy = lat3 ? busy3 : busy1;
  assign if_rdata = lat3 ? if_rdata3 : if_rdata1;
  assign d_rdata = lat3 ? d_rdata3 : d_rdata1;
  assign mem_addr = lat3 ? mem_addr3 : mem_addr1;
  assign mem_wdata = lat3 ? mem_wdata3 : mem_wdata1;
  assign stall_cnt = lat3 ? stall_cnt3 : stall_cnt1;
  assign mem_rdata1 = rd1;
  assign mem_rdata3 = p3[2];

  function automatic logic [15:0] pat(input logic [9:0] a);
    return (a == 10'h010) ? 16'hABCD : ({a[5:0], a} ^ 16'h3C5A);
  endfunction

  // behavioural memories: read data appears RD_LAT cycles after the address
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) begin
        m1[i] <= pat(10'(i));
        m3[i] <= pat(10'(i));
      end
    end else begin
      if (mem_wr1) m1[mem_addr1[9:0]] <= mem_wdata1;
      if (mem_wr3) m3[mem_addr3[9:0]] <= mem_wdata3;
    end
    rd1 <= m1[mem_addr1[9:0]];
    p3[0] <= m3[mem_addr3[9:0]];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    chk1("strobe_excl", mem_rd & mem_wr, 1'b0);
    if (if_valid) begin
      n_cmp++;
      assert (if_q.size() != 0) else begin
        n_err++;
        $error("FAIL if_unexpected observed=valid expected=no_valid");
      end
      if (if_q.size() != 0) chk16("if_rdata", if_rdata, if_q.pop_front());
    end
    if (d_valid) begin
      n_cmp++;
      assert (d_q.size() != 0) else begin
        n_err++;
        $error("FAIL d_unexpected observed=valid expected=no_valid");
      end
      if (d_q.size() != 0) begin
        exp_d = d_q.pop_front();
        if (!exp_d[16]) chk16("d_rdata", d_rdata, exp_d[15:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_checks();
    chk1("rst_rd", mem_rd, 1'b0);
    chk1("rst_wr", mem_wr, 1'b0);
    chk1("rst_if_valid", if_valid, 1'b0);
    chk1("rst_d_valid", d_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk16("rst_stall_cnt", stall_cnt, 16'h0000);
  endtask

  initial begin
    rst = 1'b1;
    lat3 = 1'b0;
    {if_req, ld_req, st_req} = 3'b000;
    if_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
    repeat (2) tick();
    if_req = 1'b1; ld_req = 1'b1;
    #1;
    rst_checks();
    if_req = 1'b0; ld_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    // single fetch, RD_LAT=1
    tick();
    if_req = 1'b1; if_addr = 16'h0010; if_q.push_back(16'hABCD);
    #1;
    chk1("f1_rd", mem_rd, 1'b1);
    chk16("f1_addr", mem_addr, 16'h0010);
    chk1("f1_stall_t", if_stall, 1'b1);
    chk1("f1_busy_t", busy, 1'b0);
    tick(); #1;
    chk1("f1_valid", if_valid, 1'b1);
    chk1("f1_stall_t1", if_stall, 1'b0);
    chk1("f1_no_regrant", mem_rd, 1'b0);
    chk1("f1_busy_t1", busy, 1'b1);
    if_req = 1'b0;
    tick(); #1;
    chk16("f1_stall_cnt", stall_cnt, 16'd1);
    chk1("f1_idle", busy, 1'b0);
    // fetch and load together: load first
    tick();
    if_req = 1'b1; if_addr = 16'h0020; ld_req = 1'b1; d_addr = 16'h0100;
    if_q.push_back(pat(10'h020)); d_q.push_back({1'b0, pat(10'h100)});
    #1;
    chk1("fl_rd_t", mem_rd, 1'b1);
    chk16("fl_addr_t", mem_addr, 16'h0100);
    chk1("fl_d_stall", d_stall, 1'b1);
    tick(); #1;
    chk1("fl_d_valid", d_valid, 1'b1);
    chk1("fl_rd_t1", mem_rd, 1'b1);
    chk16("fl_addr_t1", mem_addr, 16'h0020);
    chk1("fl_d_stall_t1", d_stall, 1'b0);
    ld_req = 1'b0;
    tick(); #1;
    chk1("fl_if_valid", if_valid, 1'b1);
    chk1("fl_rd_t2", mem_rd, 1'b0);
    if_req = 1'b0;
    tick(); #1;
    chk16("fl_stall_cnt", stall_cnt, 16'd3);
    // store plus fetch
    tick();
    st_req = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234; if_req = 1'b1; if_addr = 16'h0030;
    d_q.push_back({1'b1, 16'h0000}); if_q.push_back(pat(10'h030));
    #1;
    chk1("st_wr", mem_wr, 1'b1);
    chk1("st_rd", mem_rd, 1'b0);
    chk16("st_addr", mem_addr, 16'h0200);
    chk16("st_wdata", mem_wdata, 16'h1234);
    tick(); #1;
    chk1("st_d_valid", d_valid, 1'b1);
    chk1("st_f_rd", mem_rd, 1'b1);
    chk1("st_wr_t1", mem_wr, 1'b0);
    chk16("st_f_addr", mem_addr, 16'h0030);
    st_req = 1'b0;
    tick(); #1;
    chk1("st_if_valid", if_valid, 1'b1);
    if_req = 1'b0;
    // load back the stored word
    tick();
    ld_req = 1'b1; d_addr = 16'h0200; d_q.push_back({1'b0, 16'h1234});
    #1;
    chk1("lb_rd", mem_rd, 1'b1);
    tick(); #1;
    chk1("lb_valid", d_valid, 1'b1);
    ld_req = 1'b0;
    // load and store together act as a store
    tick();
    ld_req = 1'b1; st_req = 1'b1; d_addr = 16'h0050; d_wdata = 16'h7777;
    d_q.push_back({1'b1, 16'h0000});
    #1;
    chk1("ls_wr", mem_wr, 1'b1);
    chk1("ls_rd", mem_rd, 1'b0);
    tick(); #1;
    chk1("ls_valid", d_valid, 1'b1);
    chk1("ls_wr_t1", mem_wr, 1'b0);
    ld_req = 1'b0; st_req = 1'b0;
    tick(); #1;
    chk1("ls_once", d_valid, 1'b0);
    chk16("pre_rst_stall_cnt", stall_cnt, 16'd5);
    // switch to RD_LAT=3 through a reset
    rst = 1'b1; lat3 = 1'b1;
    tick();
    if_req = 1'b1; ld_req = 1'b1;
    #1;
    rst_checks();
    if_req = 1'b0; ld_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    // load then fetch, RD_LAT=3
    tick();
    ld_req = 1'b1; d_addr = 16'h0040; d_q.push_back({1'b0, pat(10'h040)});
    #1;
    chk1("l3_rd", mem_rd, 1'b1);
    chk16("l3_addr", mem_addr, 16'h0040);
    chk1("l3_busy_t", busy, 1'b0);
    tick();
    if_req = 1'b1; if_addr = 16'h0060; if_q.push_back(pat(10'h060));
    #1;
    chk1("l3_busy_t1", busy, 1'b1);
    chk1("l3_rd_t1", mem_rd, 1'b0);
    chk1("l3_if_stall", if_stall, 1'b1);
    tick(); #1;
    chk1("l3_busy_t2", busy, 1'b1);
    chk1("l3_d_valid_t2", d_valid, 1'b0);
    tick(); #1;
    chk1("l3_d_valid", d_valid, 1'b1);
    chk1("l3_f_rd", mem_rd, 1'b1);
    chk16("l3_f_addr", mem_addr, 16'h0060);
    ld_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick(); #1;
      chk1("l3_busy_wait", busy, 1'b1);
      chk1("l3_if_valid_early", if_valid, 1'b0);
    end
    tick(); #1;
    chk1("l3_if_valid", if_valid, 1'b1);
    chk1("l3_busy_t6", busy, 1'b1);
    if_req = 1'b0;
    tick(); #1;
    chk1("l3_idle", busy, 1'b0);
    chk16("l3_stall_cnt", stall_cnt, 16'd5);
    // reset during an outstanding load discards it
    tick();
    ld_req = 1'b1; d_addr = 16'h0044;
    #1;
    chk1("r3_rd", mem_rd, 1'b1);
    tick();
    rst = 1'b1; ld_req = 1'b0;
    #1;
    rst_checks();
    tick();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      chk1("r3_no_d_valid", d_valid, 1'b0);
      chk1("r3_idle", busy, 1'b0);
    end
    tick();
    if_req = 1'b1; if_addr = 16'h0070; if_q.push_back(pat(10'h070));
    #1;
    chk1("r3_f_rd", mem_rd, 1'b1);
    chk16("r3_f_addr", mem_addr, 16'h0070);
    for (int k = 0; k < 2; k++) begin
      tick(); #1;
      chk1("r3_f_wait", if_valid, 1'b0);
    end
    tick(); #1;
    chk1("r3_f_valid", if_valid, 1'b1);
    if_req = 1'b0;
    repeat (2) tick();
    chk16("if_q_drained", 16'(if_q.size()), 16'd0);
    chk16("d_q_drained", 16'(d_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
